// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared state encoding and timing defaults for key consumers
//
// Purpose: common definitions used by the key event decoder and its
// edge-detect front end.
//   KEY_IDLE/KEY_PRESS/KEY_HOLD : 2-bit state encodings
//   key_state_e                 : typed view of the same encodings
//   LONG_CNT_DEF                : default long-press threshold (0.5 s at 50 MHz)
//   REPEAT_CNT_DEF              : default auto-repeat period (100 ms at 50 MHz)
//   CNT_W_DEF                   : default hold counter width
package key_pkg;

  localparam logic [1:0] KEY_IDLE  = 2'd0;
  localparam logic [1:0] KEY_PRESS = 2'd1;
  localparam logic [1:0] KEY_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = KEY_IDLE,
    ST_PRESS = KEY_PRESS,
    ST_HOLD  = KEY_HOLD
  } key_state_e;

  localparam int unsigned LONG_CNT_DEF   = 25_000_000;
  localparam int unsigned REPEAT_CNT_DEF = 5_000_000;
  localparam int unsigned CNT_W_DEF      = 25;

endpackage

// File: rtl/key_edge_det.sv
// rtl/key_edge_det.sv - two-stage key level register with falling-edge detect
//
// Purpose: registers the debounced active-low key level twice and flags the
// cycle in which a press (high-to-low transition) becomes visible.
// Ports:
//   clk_i    in   system clock, rising edge
//   rst_ni   in   asynchronous active-low reset
//   key_n_i  in   debounced key level, 0 = pressed
//   key_d_o  out  first register stage (key_d)
//   fall_o   out  key_q & ~key_d, qualified so a key held low through reset
//                 release is not reported as a press
module key_edge_det (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_n_i,
  output logic key_d_o,
  output logic fall_o
);

  logic key_d_q;
  logic key_q_q;
  // valid_q rises only once key_q_q holds a real sample rather than its
  // reset value of 1; without it a key low at reset release looks like a fall.
  logic vld_d_q;
  logic vld_q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_d_q <= 1'b1;
      key_q_q <= 1'b1;
      vld_d_q <= 1'b0;
      vld_q_q <= 1'b0;
    end else begin
      key_d_q <= key_n_i;
      key_q_q <= key_d_q;
      vld_d_q <= 1'b1;
      vld_q_q <= vld_d_q;
    end
  end

  assign key_d_o = key_d_q;
  assign fall_o  = vld_q_q & key_q_q & ~key_d_q;

endmodule

// File: rtl/key_event.sv
// rtl/key_event.sv - decode debounced key level into press/release/short/long/repeat events
//
// Purpose: consumer end of the debounced key path. Produces single-cycle
// event pulses and a held level for downstream DDS step control.
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   enable         in   decode enable; low forces idle, suppresses events
//   key_n          in   debounced key level, 0 = pressed
//   press_pulse    out  one cycle on accepted press
//   release_pulse  out  one cycle on release of an accepted press
//   short_pulse    out  one cycle on release before the long threshold
//   long_pulse     out  one cycle when the hold reaches LONG_CNT cycles
//   repeat_pulse   out  one cycle every REPEAT_CNT cycles after long
//   held           out  high while an accepted press is in progress
module key_event
  import key_pkg::*;
#(
  parameter int unsigned LONG_CNT   = LONG_CNT_DEF,
  parameter int unsigned REPEAT_CNT = REPEAT_CNT_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic key_n,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic key_d;
  logic fall;

  key_edge_det u_edge (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .key_n_i (key_n),
    .key_d_o (key_d),
    .fall_o  (fall)
  );

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic press_q,   press_d;
  logic release_q, release_d;
  logic short_q,   short_d;
  logic long_q,    long_d;
  logic repeat_q,  repeat_d;
  logic held_q,    held_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    if (!enable) begin
      // Aborted presses end silently: no release for a press cut short here.
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (fall) begin
            state_d = ST_PRESS;
            cnt_d   = '0;
            press_d = 1'b1;
          end
        end
        ST_PRESS: begin
          // Release is checked first so a release landing on the long
          // threshold still counts as a short press.
          if (key_d) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            short_d   = 1'b1;
            release_d = 1'b1;
          end else if (cnt_q == LONG_LAST) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            long_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_HOLD: begin
          if (key_d) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            release_d = 1'b1;
          end else if (cnt_q == REPEAT_LAST) begin
            cnt_d    = '0;
            repeat_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // held is registered from the next state so it rises with press_pulse
    // and falls with release_pulse.
    held_d = (state_d != ST_IDLE);
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_pulse   = short_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;
  assign held          = held_q;

endmodule
